boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/riscv_types.sv | 15 +
 rtl/boot_word_asm.sv | 52 +++++
 rtl/boot_loader.sv | 119 +++++++++++
 tb/tb_boot_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_types.sv
// Shared types and constants for the boot loader and its word assembler.
package riscv_types;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_RUN,
        ST_ERR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/boot_word_asm.sv
// Byte-lane assembler for the boot loader: places incoming bytes into the
// lane selected by a 2-bit byte index, keeps a running XOR of every data
// byte, and flags the byte that completes a little-endian word.
module boot_word_asm #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic [7:0]       checksum_o,
    output logic             word_done_o
);

    logic [WIDTH-1:0] lanes_q;
    logic [1:0]       byteIdx_q;
    logic [7:0]       xorSum_q;

    // Current word with the incoming byte dropped into its lane, so the
    // completing byte is already visible in the word handed to memory.
    always_comb begin
        word_o = lanes_q;
        for (int i = 0; i < 4; i++) begin
            if (byteIdx_q == 2'(i)) begin
                word_o[8*i +: 8] = byte_i;
            end
        end
    end

    assign word_done_o = valid_i && (byteIdx_q == 2'd3);
    assign checksum_o  = xorSum_q;

    // Lane register, byte index and running checksum; cleared at frame start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lanes_q   <= '0;
            byteIdx_q <= '0;
            xorSum_q  <= '0;
        end else if (clear_i) begin
            lanes_q   <= '0;
            byteIdx_q <= '0;
            xorSum_q  <= '0;
        end else if (valid_i) begin
            lanes_q   <= word_o;
            byteIdx_q <= byteIdx_q + 2'd1;
            xorSum_q  <= xorSum_q ^ byte_i;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: parses SYNC / count / data / checksum frames from a
// byte stream, writes assembled words into instruction memory, and releases
// the core from reset only after a frame's checksum has been verified.
module boot_loader
    import riscv_types::*;
#(
    parameter int         WIDTH = 32,
    parameter int         INDEX = 6,
    parameter logic [7:0] SYNC  = SYNC_BYTE
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       rx_data_in,
    input  logic             rx_valid_in,
    output logic             rx_ready_out,
    output logic             imem_we_out,
    output logic [INDEX-1:0] imem_addr_out,
    output logic [WIDTH-1:0] imem_data_out,
    output logic             core_nrst_out,
    output logic             done_out,
    output logic             error_out
);

    localparam int unsigned MAX_WORDS = 1 << INDEX;

    loader_state_e    state_q, state_d;
    logic             rxReady_q;
    logic             imemWe_q;
    logic [INDEX-1:0] imemAddr_q;
    logic [WIDTH-1:0] imemData_q;
    logic             coreNrst_q;
    logic             done_q;
    logic             error_q;
    logic [INDEX:0]   count_q;
    logic [INDEX:0]   wordAddr_q;
    logic [INDEX:0]   wordAddrInc;

    logic             accept;
    logic             countOk;
    logic             asmClear;
    logic             asmValid;
    logic             wordDone;
    logic [WIDTH-1:0] asmWord;
    logic [7:0]       checksum;

    assign accept      = rx_valid_in && rxReady_q;
    assign countOk     = (rx_data_in != 8'd0) && (32'(rx_data_in) <= MAX_WORDS);
    assign asmClear    = (state_q == ST_COUNT) && accept && countOk;
    assign asmValid    = (state_q == ST_DATA) && accept;
    assign wordAddrInc = wordAddr_q + (INDEX+1)'(1);

    boot_word_asm #(
        .WIDTH(WIDTH)
    ) u_word_asm (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .clear_i    (asmClear),
        .valid_i    (asmValid),
        .byte_i     (rx_data_in),
        .word_o     (asmWord),
        .checksum_o (checksum),
        .word_done_o(wordDone)
    );

    // Next-state decision for the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && rx_data_in == SYNC) state_d = ST_COUNT;
            ST_COUNT: if (accept) state_d = countOk ? ST_DATA : ST_ERR;
            ST_DATA:  if (wordDone && wordAddrInc == count_q) state_d = ST_CHECK;
            ST_CHECK: if (accept) state_d = (rx_data_in == checksum) ? ST_RUN : ST_ERR;
            ST_RUN:   state_d = ST_RUN;
            ST_ERR:   if (accept && rx_data_in == SYNC) state_d = ST_COUNT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register plus all registered outputs, memory write pulse and counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            rxReady_q  <= 1'b0;
            imemWe_q   <= 1'b0;
            imemAddr_q <= '0;
            imemData_q <= '0;
            coreNrst_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            wordAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            rxReady_q  <= (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
            error_q    <= (state_d == ST_ERR);
            coreNrst_q <= (state_q == ST_RUN);
            imemWe_q   <= wordDone;
            if (asmClear) begin
                count_q    <= (INDEX+1)'(rx_data_in);
                wordAddr_q <= '0;
            end
            if (wordDone) begin
                imemAddr_q <= wordAddr_q[INDEX-1:0];
                imemData_q <= asmWord;
                wordAddr_q <= wordAddrInc;
            end
        end
    end

    assign rx_ready_out  = rxReady_q;
    assign imem_we_out   = imemWe_q;
    assign imem_addr_out = imemAddr_q;
    assign imem_data_out = imemData_q;
    assign core_nrst_out = coreNrst_q;
    assign done_out      = done_q;
    assign error_out     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of whole-frame vectors, hand
// sequences for the timing corner cases, and randomized frames compared
// against a frame-level reference parser.
module tb_boot_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic        imem_we_out;
    logic [5:0]  imem_addr_out;
    logic [31:0] imem_data_out;
    logic        core_nrst_out;
    logic        done_out;
    logic        error_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  streamQ[$];
    int          expAddr[$];
    logic [31:0] expData[$];
    int          gotAddr[$];
    logic [31:0] gotData[$];
    int          weViolations = 0;
    logic        prevWe = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] bytes [0:11];
        int         len;
        bit         expDone;
        bit         expErr;
        int         expWrites;
    } vec_t;

    vec_t vecs [0:5];

    boot_loader dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .rx_ready_out (rx_ready_out),
        .imem_we_out  (imem_we_out),
        .imem_addr_out(imem_addr_out),
        .imem_data_out(imem_data_out),
        .core_nrst_out(core_nrst_out),
        .done_out     (done_out),
        .error_out    (error_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Records every instruction-memory write and flags any strobe longer than one cycle.
    always @(negedge clk_in) begin
        if (rst_in && imem_we_out) begin
            gotAddr.push_back(int'(imem_addr_out));
            gotData.push_back(imem_data_out);
            if (prevWe) weViolations <= weViolations + 1;
        end
        prevWe <= imem_we_out;
    end

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic doReset();
        rx_valid_in = 1'b0;
        rx_data_in  = 8'h00;
        rst_in      = 1'b0;
        repeat (2) @(negedge clk_in);
        gotAddr.delete();
        gotData.delete();
        rst_in = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit taken;
        bit rdy;
        taken = 0;
        @(negedge clk_in);
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        for (int c = 0; c < 50 && !taken; c++) begin
            if (c > 0) @(negedge clk_in);
            rdy = rx_ready_out;
            @(posedge clk_in);
            if (rdy) taken = 1;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout got no accept expected accept of %h", b);
        end
    endtask

    task automatic applyStimulus(input bit useGaps);
        int g;
        for (int i = 0; i < streamQ.size(); i++) begin
            if (useGaps) begin
                g = $urandom_range(10, 0);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk_in);
                    rx_valid_in = 1'b0;
                end
            end
            sendByte(streamQ[i]);
        end
        @(negedge clk_in);
        rx_valid_in = 1'b0;
    endtask

    // Frame-level reference: scan for SYNC, read the count, take whole
    // little-endian words, then compare the trailing byte with their XOR.
    task automatic runModel(output bit mDone, output bit mErr);
        int          p;
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        bit          stop;
        expAddr.delete();
        expData.delete();
        mDone = 0;
        mErr  = 0;
        p     = 0;
        stop  = 0;
        while (!stop && p < streamQ.size()) begin
            if (streamQ[p] != SYNC) begin
                p++;
            end else begin
                mErr = 0;
                p++;
                if (p >= streamQ.size()) begin
                    stop = 1;
                end else begin
                    n = int'(streamQ[p]);
                    p++;
                    if (n < 1 || n > 64) begin
                        mErr = 1;
                    end else begin
                        x = 8'h00;
                        for (int k = 0; k < n && !stop; k++) begin
                            if (p + 4 > streamQ.size()) begin
                                stop = 1;
                            end else begin
                                w = {streamQ[p+3], streamQ[p+2], streamQ[p+1], streamQ[p]};
                                expAddr.push_back(k);
                                expData.push_back(w);
                                x = x ^ streamQ[p] ^ streamQ[p+1] ^ streamQ[p+2] ^ streamQ[p+3];
                                p += 4;
                            end
                        end
                        if (!stop) begin
                            if (p >= streamQ.size()) begin
                                stop = 1;
                            end else begin
                                if (streamQ[p] == x) begin
                                    mDone = 1;
                                    stop  = 1;
                                end else begin
                                    mErr = 1;
                                end
                                p++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input bit expDone, input bit expErr);
        int n;
        checkValue({name, ".done"}, 32'(done_out), 32'(expDone));
        checkValue({name, ".error"}, 32'(error_out), 32'(expErr));
        @(negedge clk_in);
        checkValue({name, ".coreNrst"}, 32'(core_nrst_out), 32'(expDone));
        checkValue({name, ".rxReady"}, 32'(rx_ready_out), 32'(!expDone));
        checkValue({name, ".writeCount"}, 32'(gotAddr.size()), 32'(expAddr.size()));
        n = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
        for (int i = 0; i < n; i++) begin
            checkValue($sformatf("%s.addr%0d", name, i), 32'(gotAddr[i]), 32'(expAddr[i]));
            checkValue($sformatf("%s.data%0d", name, i), gotData[i], expData[i]);
        end
        checkValue({name, ".weSingleCycle"}, 32'(weViolations), 32'd0);
    endtask

    task automatic pushNominal(input logic [7:0] csum);
        streamQ.push_back(SYNC);
        streamQ.push_back(8'h02);
        streamQ.push_back(8'h13); streamQ.push_back(8'h00);
        streamQ.push_back(8'h00); streamQ.push_back(8'h00);
        streamQ.push_back(8'h93); streamQ.push_back(8'h00);
        streamQ.push_back(8'h10); streamQ.push_back(8'h00);
        streamQ.push_back(csum);
    endtask

    initial begin
        bit          mDone;
        bit          mErr;
        bit          sawReady;
        int          n;
        logic [7:0]  x;
        logic [7:0]  b;

        vecs[0].name = "nominal";
        vecs[0].bytes = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h00};
        vecs[0].len = 11; vecs[0].expDone = 1; vecs[0].expErr = 0; vecs[0].expWrites = 2;
        vecs[1].name = "badChecksum";
        vecs[1].bytes = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81, 8'h00};
        vecs[1].len = 11; vecs[1].expDone = 0; vecs[1].expErr = 1; vecs[1].expWrites = 2;
        vecs[2].name = "countZero";
        vecs[2].bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].len = 2; vecs[2].expDone = 0; vecs[2].expErr = 1; vecs[2].expWrites = 0;
        vecs[3].name = "countOver";
        vecs[3].bytes = '{8'hA5, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].len = 2; vecs[3].expDone = 0; vecs[3].expErr = 1; vecs[3].expWrites = 0;
        vecs[4].name = "noiseThenFrame";
        vecs[4].bytes = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
        vecs[4].len = 9; vecs[4].expDone = 1; vecs[4].expErr = 0; vecs[4].expWrites = 1;
        vecs[5].name = "errThenFrame";
        vecs[5].bytes = '{8'hA5, 8'h00, 8'h77, 8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00};
        vecs[5].len = 10; vecs[5].expDone = 1; vecs[5].expErr = 0; vecs[5].expWrites = 1;

        $display("[TB] reset values");
        rx_valid_in = 1'b0;
        rx_data_in  = 8'h00;
        rst_in      = 1'b0;
        repeat (2) @(negedge clk_in);
        checkValue("reset.rxReady", 32'(rx_ready_out), 32'd0);
        checkValue("reset.we", 32'(imem_we_out), 32'd0);
        checkValue("reset.addr", 32'(imem_addr_out), 32'd0);
        checkValue("reset.data", imem_data_out, 32'd0);
        checkValue("reset.coreNrst", 32'(core_nrst_out), 32'd0);
        checkValue("reset.done", 32'(done_out), 32'd0);
        checkValue("reset.error", 32'(error_out), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkValue("readyAfterReset", 32'(rx_ready_out), 32'd1);

        $display("[TB] table vectors");
        for (int v = 0; v < 6; v++) begin
            doReset();
            streamQ.delete();
            for (int i = 0; i < vecs[v].len; i++) streamQ.push_back(vecs[v].bytes[i]);
            applyStimulus(1'b0);
            runModel(mDone, mErr);
            checkValue({vecs[v].name, ".tableWrites"}, 32'(gotAddr.size()), 32'(vecs[v].expWrites));
            checkOutput(vecs[v].name, vecs[v].expDone, vecs[v].expErr);
        end

        $display("[TB] core reset release timing and no accept in RUN");
        doReset();
        streamQ.delete();
        pushNominal(8'h90);
        applyStimulus(1'b0);
        checkValue("run.doneNow", 32'(done_out), 32'd1);
        checkValue("run.coreNrstNotYet", 32'(core_nrst_out), 32'd0);
        runModel(mDone, mErr);
        checkOutput("run", 1'b1, 1'b0);
        sawReady = 0;
        rx_valid_in = 1'b1;
        rx_data_in  = SYNC;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (rx_ready_out) sawReady = 1;
        end
        rx_valid_in = 1'b0;
        checkValue("run.neverReady", 32'(sawReady), 32'd0);
        checkValue("run.noExtraWrites", 32'(gotAddr.size()), 32'd2);
        checkValue("run.stillDone", 32'(done_out), 32'd1);

        $display("[TB] recovery after bad checksum");
        doReset();
        streamQ.delete();
        pushNominal(8'h81);
        pushNominal(8'h90);
        applyStimulus(1'b0);
        runModel(mDone, mErr);
        checkOutput("recovery", 1'b1, 1'b0);

        $display("[TB] nominal frame with random gaps");
        doReset();
        streamQ.delete();
        pushNominal(8'h90);
        applyStimulus(1'b1);
        runModel(mDone, mErr);
        checkOutput("gaps", 1'b1, 1'b0);

        $display("[TB] reset in the middle of data");
        doReset();
        streamQ.delete();
        pushNominal(8'h90);
        while (streamQ.size() > 8) void'(streamQ.pop_back());
        applyStimulus(1'b0);
        checkValue("midReset.preData", imem_data_out, 32'h0000_0013);
        #2 rst_in = 1'b0;
        #1;
        checkValue("midReset.rxReady", 32'(rx_ready_out), 32'd0);
        checkValue("midReset.we", 32'(imem_we_out), 32'd0);
        checkValue("midReset.addr", 32'(imem_addr_out), 32'd0);
        checkValue("midReset.data", imem_data_out, 32'd0);
        checkValue("midReset.coreNrst", 32'(core_nrst_out), 32'd0);
        checkValue("midReset.done", 32'(done_out), 32'd0);
        checkValue("midReset.error", 32'(error_out), 32'd0);
        @(negedge clk_in);
        gotAddr.delete();
        gotData.delete();
        rst_in = 1'b1;
        streamQ.delete();
        streamQ.push_back(8'h00);
        streamQ.push_back(8'hFF);
        pushNominal(8'h90);
        applyStimulus(1'b1);
        runModel(mDone, mErr);
        checkOutput("restart", 1'b1, 1'b0);

        $display("[TB] largest frame");
        doReset();
        streamQ.delete();
        streamQ.push_back(SYNC);
        streamQ.push_back(8'd64);
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(255, 0));
            streamQ.push_back(b);
            x = x ^ b;
        end
        streamQ.push_back(x);
        applyStimulus(1'b0);
        runModel(mDone, mErr);
        checkOutput("maxFrame", 1'b1, 1'b0);

        $display("[TB] random frames");
        for (int it = 0; it < 15; it++) begin
            doReset();
            streamQ.delete();
            n = $urandom_range(2, 0);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(255, 0));
                if (b == SYNC) b = 8'h00;
                streamQ.push_back(b);
            end
            streamQ.push_back(SYNC);
            n = $urandom_range(8, 1);
            streamQ.push_back(8'(n));
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom_range(255, 0));
                streamQ.push_back(b);
                x = x ^ b;
            end
            if ($urandom_range(1, 0) == 1) x = x ^ 8'(1 << $urandom_range(7, 0));
            streamQ.push_back(x);
            applyStimulus(1'b1);
            runModel(mDone, mErr);
            checkOutput($sformatf("random%0d", it), mDone, mErr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
